// File: rtl/universal_counter_stepped.sv
// universal_counter_stepped
//   Parametrised up/down/bounce counter with programmable step, wrap to
//   BeginCount, registered direction and registered terminal-count pulse.
//   Used for Pong ball/paddle positions and VGA-style scan counters.
//
// Ports
//   CLOCK          system clock, rising edge
//   Reset          asynchronous, active-high; Q = BeginCount, Dir = 0, TC = 0
//   Enable         count enable; 0 freezes Q/Dir and forces TerminalCount low
//   Mode[2:0]      000 hold, 001 up-wrap, 010 down-wrap, 011 load,
//                  100 bounce, 101 reverse, 110/111 hold
//   P              parallel load value
//   BeginCount     lower bound of the range
//   EndCount       upper bound of the range
//   Step           unsigned step per enabled edge
//   Q              registered count
//   Dir            registered direction (0 = up, 1 = down)
//   TerminalCount  one-cycle registered pulse after a wrap or bounce edge
//   AtBegin        combinational Q == BeginCount
//   AtEnd          combinational Q == EndCount
module universal_counter_stepped #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned STEP_WIDTH = 4
) (
  input  logic                  CLOCK,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [2:0]            Mode,
  input  logic [WIDTH-1:0]      P,
  input  logic [WIDTH-1:0]      BeginCount,
  input  logic [WIDTH-1:0]      EndCount,
  input  logic [STEP_WIDTH-1:0] Step,
  output logic [WIDTH-1:0]      Q,
  output logic                  Dir,
  output logic                  TerminalCount,
  output logic                  AtBegin,
  output logic                  AtEnd
);

  typedef enum logic [2:0] {
    MODE_HOLD      = 3'b000,
    MODE_UP_WRAP   = 3'b001,
    MODE_DOWN_WRAP = 3'b010,
    MODE_LOAD      = 3'b011,
    MODE_BOUNCE    = 3'b100,
    MODE_REVERSE   = 3'b101,
    MODE_RSVD6     = 3'b110,
    MODE_RSVD7     = 3'b111
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(Mode);

  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  // All arithmetic is one bit wider than the count so sums never overflow
  // and Begin + Step can be compared against Q directly.
  logic [WIDTH:0] q_ext, step_ext, begin_ext, end_ext;
  logic [WIDTH:0] up, begin_plus_step;
  logic [WIDTH-1:0] dn;

  always_comb begin
    q_ext           = {1'b0, q_q};
    step_ext        = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, Step};
    begin_ext       = {1'b0, BeginCount};
    end_ext         = {1'b0, EndCount};
    up              = q_ext + step_ext;
    begin_plus_step = begin_ext + step_ext;
    // Borrow case (Q < Step) is always caught by the Begin + Step compare
    // before dn is selected, so the truncated difference is safe.
    dn              = WIDTH'(q_ext - step_ext);
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      q_q   <= BeginCount;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end

  always_comb begin
    q_d   = q_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (Enable) begin
      case (mode)
        MODE_UP_WRAP: begin
          if (up > end_ext) begin
            q_d  = BeginCount;
            tc_d = 1'b1;
          end else begin
            q_d = up[WIDTH-1:0];
          end
        end
        MODE_DOWN_WRAP: begin
          if (q_ext < begin_plus_step) begin
            q_d  = EndCount;
            tc_d = 1'b1;
          end else begin
            q_d = dn;
          end
        end
        MODE_LOAD: q_d = P;
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (up >= end_ext) begin
              q_d   = EndCount;
              dir_d = 1'b1;
              tc_d  = 1'b1;
            end else begin
              q_d = up[WIDTH-1:0];
            end
          end else begin
            if (q_ext <= begin_plus_step) begin
              q_d   = BeginCount;
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end else begin
              q_d = dn;
            end
          end
        end
        MODE_REVERSE: dir_d = ~dir_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    Q             = q_q;
    Dir           = dir_q;
    TerminalCount = tc_q;
    AtBegin       = (q_q == BeginCount);
    AtEnd         = (q_q == EndCount);
  end

endmodule

// File: tb/tb_universal_counter_stepped.sv
// tb_universal_counter_stepped
//   Directed-vector bench for universal_counter_stepped (WIDTH 10, STEP_WIDTH 4).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_universal_counter_stepped;

  logic       CLOCK;
  logic       Reset;
  logic       Enable;
  logic [2:0] Mode;
  logic [9:0] P;
  logic [9:0] BeginCount;
  logic [9:0] EndCount;
  logic [3:0] Step;
  logic [9:0] Q;
  logic       Dir;
  logic       TerminalCount;
  logic       AtBegin;
  logic       AtEnd;

  int n_cmp;
  int n_err;

  universal_counter_stepped #(.WIDTH(10), .STEP_WIDTH(4)) dut (
    .CLOCK(CLOCK),
    .Reset(Reset),
    .Enable(Enable),
    .Mode(Mode),
    .P(P),
    .BeginCount(BeginCount),
    .EndCount(EndCount),
    .Step(Step),
    .Q(Q),
    .Dir(Dir),
    .TerminalCount(TerminalCount),
    .AtBegin(AtBegin),
    .AtEnd(AtEnd)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic load(input logic [9:0] v);
    Mode = 3'b011;
    P    = v;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0; Enable = 1'b0; Mode = 3'b000; P = '0;
    BeginCount = 10'd5; EndCount = 10'd100; Step = 4'd4;
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (Q !== 10'd5) begin n_err++; $display("FAIL reset_q: got %0d expected 5", Q); end
    n_cmp++; if (Dir !== 1'b0) begin n_err++; $display("FAIL reset_dir: got %b expected 0", Dir); end
    n_cmp++; if (TerminalCount !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %b expected 0", TerminalCount); end
    n_cmp++; if (AtBegin !== 1'b1) begin n_err++; $display("FAIL reset_atbegin: got %b expected 1", AtBegin); end
    @(negedge CLOCK);
    Reset = 1'b0; Enable = 1'b1; Mode = 3'b001;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (Q !== 10'(5 + 4 * (i + 1))) begin
        n_err++; $display("FAIL reset_count_%0d: got %0d expected %0d", i, Q, 5 + 4 * (i + 1));
      end
    end
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (Q !== 10'd5) begin n_err++; $display("FAIL reset_async_q: got %0d expected 5", Q); end
    n_cmp++; if (Dir !== 1'b0) begin n_err++; $display("FAIL reset_async_dir: got %b expected 0", Dir); end
    #1 Reset = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [9:0] eq [4] = '{10'd5, 10'd8, 10'd2, 10'd5};
    logic       et [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tick();
    BeginCount = 10'd2; EndCount = 10'd10; Step = 4'd3; Enable = 1'b1;
    load(10'd2);
    Mode = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (Q !== eq[i]) begin n_err++; $display("FAIL up_wrap_q_%0d: got %0d expected %0d", i, Q, eq[i]); end
      n_cmp++; if (TerminalCount !== et[i]) begin n_err++; $display("FAIL up_wrap_tc_%0d: got %b expected %b", i, TerminalCount, et[i]); end
    end
    Step = 4'd1;
    load(10'd9);
    Mode = 3'b001;
    tick();
    n_cmp++; if (Q !== 10'd10 || TerminalCount !== 1'b0) begin n_err++; $display("FAIL up_wrap_s1_a: got q=%0d tc=%b expected q=10 tc=0", Q, TerminalCount); end
    n_cmp++; if (AtEnd !== 1'b1) begin n_err++; $display("FAIL up_wrap_atend: got %b expected 1", AtEnd); end
    tick();
    n_cmp++; if (Q !== 10'd2 || TerminalCount !== 1'b1) begin n_err++; $display("FAIL up_wrap_s1_b: got q=%0d tc=%b expected q=2 tc=1", Q, TerminalCount); end
    Step = 4'd0;
    load(10'd7);
    Mode = 3'b001;
    tick();
    n_cmp++; if (Q !== 10'd7 || TerminalCount !== 1'b0) begin n_err++; $display("FAIL up_wrap_s0_hold: got q=%0d tc=%b expected q=7 tc=0", Q, TerminalCount); end
    load(10'd12);
    Mode = 3'b001;
    tick();
    n_cmp++; if (Q !== 10'd2 || TerminalCount !== 1'b1) begin n_err++; $display("FAIL up_wrap_s0_wrap: got q=%0d tc=%b expected q=2 tc=1", Q, TerminalCount); end
  endtask

  task automatic test_down_wrap();
    logic [9:0] eq [3] = '{10'd6, 10'd2, 10'd10};
    logic       et [3] = '{1'b0, 1'b0, 1'b1};
    BeginCount = 10'd2; EndCount = 10'd10; Step = 4'd4;
    load(10'd10);
    Mode = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (Q !== eq[i]) begin n_err++; $display("FAIL down_wrap_q_%0d: got %0d expected %0d", i, Q, eq[i]); end
      n_cmp++; if (TerminalCount !== et[i]) begin n_err++; $display("FAIL down_wrap_tc_%0d: got %b expected %b", i, TerminalCount, et[i]); end
    end
    BeginCount = 10'd0; Step = 4'd3;
    load(10'd1);
    Mode = 3'b010;
    tick();
    n_cmp++; if (Q !== 10'd10 || TerminalCount !== 1'b1) begin n_err++; $display("FAIL down_wrap_borrow: got q=%0d tc=%b expected q=10 tc=1", Q, TerminalCount); end
    BeginCount = 10'd2; Step = 4'd0;
    load(10'd1);
    Mode = 3'b010;
    tick();
    n_cmp++; if (Q !== 10'd10 || TerminalCount !== 1'b1) begin n_err++; $display("FAIL down_wrap_s0: got q=%0d tc=%b expected q=10 tc=1", Q, TerminalCount); end
  endtask

  task automatic test_bounce();
    logic [9:0] eq [3] = '{10'd637, 10'd639, 10'd632};
    logic       ed [3] = '{1'b0, 1'b1, 1'b1};
    logic       et [3] = '{1'b0, 1'b1, 1'b0};
    logic [9:0] fq [2] = '{10'd0, 10'd7};
    logic       ft [2] = '{1'b1, 1'b0};
    BeginCount = 10'd0; EndCount = 10'd639; Step = 4'd7;
    load(10'd630);
    Mode = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (Q !== eq[i]) begin n_err++; $display("FAIL bounce_top_q_%0d: got %0d expected %0d", i, Q, eq[i]); end
      n_cmp++; if (Dir !== ed[i]) begin n_err++; $display("FAIL bounce_top_dir_%0d: got %b expected %b", i, Dir, ed[i]); end
      n_cmp++; if (TerminalCount !== et[i]) begin n_err++; $display("FAIL bounce_top_tc_%0d: got %b expected %b", i, TerminalCount, et[i]); end
      n_cmp++; if (Q > 10'd639) begin n_err++; $display("FAIL bounce_range_%0d: got %0d expected <= 639", i, Q); end
    end
    load(10'd5);
    n_cmp++; if (Dir !== 1'b1) begin n_err++; $display("FAIL bounce_load_keeps_dir: got %b expected 1", Dir); end
    Mode = 3'b100;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (Q !== fq[i]) begin n_err++; $display("FAIL bounce_bot_q_%0d: got %0d expected %0d", i, Q, fq[i]); end
      n_cmp++; if (Dir !== 1'b0) begin n_err++; $display("FAIL bounce_bot_dir_%0d: got %b expected 0", i, Dir); end
      n_cmp++; if (TerminalCount !== ft[i]) begin n_err++; $display("FAIL bounce_bot_tc_%0d: got %b expected %b", i, TerminalCount, ft[i]); end
    end
  endtask

  task automatic test_enable_load();
    load(10'd636);
    Mode = 3'b100;
    Enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (Q !== 10'd636 || Dir !== 1'b0 || TerminalCount !== 1'b0) begin
        n_err++; $display("FAIL enable_freeze_%0d: got q=%0d dir=%b tc=%b expected q=636 dir=0 tc=0", i, Q, Dir, TerminalCount);
      end
    end
    Enable = 1'b1;
    tick();
    n_cmp++; if (Q !== 10'd639 || Dir !== 1'b1 || TerminalCount !== 1'b1) begin n_err++; $display("FAIL enable_resume: got q=%0d dir=%b tc=%b expected q=639 dir=1 tc=1", Q, Dir, TerminalCount); end
    load(10'd1023);
    n_cmp++; if (Q !== 10'd1023 || TerminalCount !== 1'b0 || Dir !== 1'b1) begin n_err++; $display("FAIL load_1023: got q=%0d tc=%b dir=%b expected q=1023 tc=0 dir=1", Q, TerminalCount, Dir); end
    Mode = 3'b001;
    tick();
    n_cmp++; if (Q !== 10'd0 || TerminalCount !== 1'b1) begin n_err++; $display("FAIL load_out_of_range_wrap: got q=%0d tc=%b expected q=0 tc=1", Q, TerminalCount); end
    n_cmp++; if (AtBegin !== 1'b1) begin n_err++; $display("FAIL load_atbegin: got %b expected 1", AtBegin); end
  endtask

  task automatic test_reverse_reserved();
    logic [2:0] hold_modes [3] = '{3'b110, 3'b111, 3'b000};
    Mode = 3'b101;
    tick();
    n_cmp++; if (Dir !== 1'b0 || Q !== 10'd0 || TerminalCount !== 1'b0) begin n_err++; $display("FAIL reverse_a: got dir=%b q=%0d tc=%b expected dir=0 q=0 tc=0", Dir, Q, TerminalCount); end
    tick();
    n_cmp++; if (Dir !== 1'b1 || Q !== 10'd0) begin n_err++; $display("FAIL reverse_b: got dir=%b q=%0d expected dir=1 q=0", Dir, Q); end
    for (int i = 0; i < 3; i++) begin
      Mode = hold_modes[i];
      tick();
      n_cmp++;
      if (Q !== 10'd0 || Dir !== 1'b1 || TerminalCount !== 1'b0) begin
        n_err++; $display("FAIL hold_mode_%0d: got q=%0d dir=%b tc=%b expected q=0 dir=1 tc=0", hold_modes[i], Q, Dir, TerminalCount);
      end
    end
    BeginCount = 10'd639; EndCount = 10'd639; Step = 4'd0;
    load(10'd639);
    Mode = 3'b101;
    tick();
    Mode = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (Q !== 10'd639 || Dir !== ((i % 2) == 0) || TerminalCount !== 1'b1) begin
        n_err++; $display("FAIL bounce_step0_%0d: got q=%0d dir=%b tc=%b expected q=639 dir=%b tc=1", i, Q, Dir, TerminalCount, (i % 2) == 0);
      end
    end
    n_cmp++; if (AtBegin !== 1'b1 || AtEnd !== 1'b1) begin n_err++; $display("FAIL bounce_step0_flags: got atbegin=%b atend=%b expected 1 1", AtBegin, AtEnd); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_bounce();
    test_enable_load();
    test_reverse_reserved();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
